frontend_pipe_ctrl: RTL

Parametrised stop/flush controller for the front-end pipeline (PC, BTB/TAGE/RAS, ICache, predecode, FTQ, issue). It takes per-stage stall and flush requests, a trap request and the ROB redirect, and drives one stop and one flush line per stage. It replaces fixed per-unit stop/flush wiring with a stage-indexed priority scheme. It adds a trap-hold FSM, post-redirect recovery bubbles, a stall watchdog and optional performance counters.

---
 rtl/frontend_pipe_ctrl_pkg.sv | 14 +
 rtl/frontend_pipe_ctrl_fe_stall_watchdog.sv | 37 +++
 rtl/frontend_pipe_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/frontend_pipe_ctrl_pkg.sv
// Shared state encoding and default parameters for the front-end stop/flush controller.
package frontend_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FE_CTRL_RUN     = 2'd0,
    FE_CTRL_TRAP    = 2'd1,
    FE_CTRL_RECOVER = 2'd2
  } feCtrlState_e;

  localparam int FE_CTRL_NUM_STAGES    = 6;
  localparam int FE_CTRL_RECOVER_CYC   = 1;
  localparam int FE_CTRL_STALL_TIMEOUT = 1024;

endpackage

// File: rtl/frontend_pipe_ctrl_fe_stall_watchdog.sv
// Stall watchdog: counts consecutive stage-0 stop cycles in RUN, sets a sticky timeout.
module fe_stall_watchdog
  import frontend_pipe_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = FE_CTRL_STALL_TIMEOUT
) (
  input  logic Clk,
  input  logic Rest,
  input  logic stop0,
  input  logic inRun,
  input  logic clear,
  output logic stallTimeout
);

  localparam int WD_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_TIMEOUT);

  logic [WD_W-1:0] wdCnt;

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      wdCnt        <= '0;
      stallTimeout <= 1'b0;
    end else if (clear) begin
      wdCnt        <= '0;
      stallTimeout <= 1'b0;
    end else begin
      // Timeout is registered off the counter, so it lands one cycle after the limit is reached.
      stallTimeout <= stallTimeout | (wdCnt == WD_LIMIT);
      if (!stop0)
        wdCnt <= '0;
      else if (inRun && (wdCnt != WD_LIMIT))
        wdCnt <= wdCnt + 1'b1;
    end
  end

endmodule

// File: rtl/frontend_pipe_ctrl.sv
// Front-end stop/flush controller with trap-hold FSM, recovery bubbles and stall watchdog.
// Optional perf counters are enabled by defining FE_CTRL_PERF_EN.
module frontend_pipe_ctrl
  import frontend_pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES    = FE_CTRL_NUM_STAGES,
  parameter int RECOVER_CYC   = FE_CTRL_RECOVER_CYC,
  parameter int STALL_TIMEOUT = FE_CTRL_STALL_TIMEOUT
) (
  input  logic                  Clk,
  input  logic                  Rest,
  input  logic                  ROBredir,
  input  logic [NUM_STAGES-1:0] StallReq,
  input  logic [NUM_STAGES-1:0] FlushReq,
  input  logic                  TrapReq,
  output logic [NUM_STAGES-1:0] StageStop,
  output logic [NUM_STAGES-1:0] StageFlush,
  output logic                  TrapActive,
  output logic                  StallTimeout,
  output logic [31:0]           PerfStallCnt,
  output logic [31:0]           PerfFlushCnt
);

  localparam int REC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam logic [REC_W-1:0] REC_LAST = REC_W'((RECOVER_CYC > 0) ? RECOVER_CYC - 1 : 0);

  feCtrlState_e     state, stateNxt;
  logic [REC_W-1:0] recCnt, recCntNxt;
  logic             trapStop;
  logic             inRecover;

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state  <= FE_CTRL_RUN;
      recCnt <= '0;
    end else begin
      state  <= stateNxt;
      recCnt <= recCntNxt;
    end
  end

  // A redirect always wins over a trap and (re)starts the recovery bubble.
  always_comb begin
    stateNxt  = state;
    recCntNxt = recCnt;
    if (ROBredir) begin
      stateNxt  = (RECOVER_CYC > 0) ? FE_CTRL_RECOVER : FE_CTRL_RUN;
      recCntNxt = '0;
    end else begin
      unique case (state)
        FE_CTRL_RUN: begin
          if (TrapReq) stateNxt = FE_CTRL_TRAP;
        end
        FE_CTRL_TRAP: ;
        FE_CTRL_RECOVER: begin
          if (recCnt == REC_LAST) begin
            stateNxt  = FE_CTRL_RUN;
            recCntNxt = '0;
          end else begin
            recCntNxt = recCnt + 1'b1;
          end
        end
        default: stateNxt = FE_CTRL_RUN;
      endcase
    end
  end

  assign trapStop   = (TrapReq | (state == FE_CTRL_TRAP)) & ~ROBredir;
  assign inRecover  = (state == FE_CTRL_RECOVER);
  assign TrapActive = (state == FE_CTRL_TRAP);

  // Stage j is killed by a flush from any older stage; flush suppresses stop.
  for (genvar j = 0; j < NUM_STAGES; j++) begin : gStage
    logic rawStop;
    if (j == NUM_STAGES - 1) begin : gOldest
      assign StageFlush[j] = ROBredir;
    end else begin : gYounger
      assign StageFlush[j] = ROBredir | (|FlushReq[NUM_STAGES-1:j+1]);
    end
    assign rawStop      = (|StallReq[NUM_STAGES-1:j]) | trapStop | ((j == 0) && inRecover);
    assign StageStop[j] = rawStop & ~StageFlush[j];
  end

  fe_stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) uWatchdog (
    .Clk          (Clk),
    .Rest         (Rest),
    .stop0        (StageStop[0]),
    .inRun        (state == FE_CTRL_RUN),
    .clear        (ROBredir),
    .stallTimeout (StallTimeout)
  );

`ifdef FE_CTRL_PERF_EN
  logic [31:0] perfStall, perfFlush;

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      perfStall <= '0;
      perfFlush <= '0;
    end else begin
      if (StageStop[0] && (perfStall != '1)) perfStall <= perfStall + 1'b1;
      if ((|StageFlush) && (perfFlush != '1)) perfFlush <= perfFlush + 1'b1;
    end
  end

  assign PerfStallCnt = perfStall;
  assign PerfFlushCnt = perfFlush;
`else
  assign PerfStallCnt = '0;
  assign PerfFlushCnt = '0;
`endif

endmodule
